// File: rtl/aes_uart_pkg.sv
// Shared constants, parser state encoding and helpers for the AES UART loader.
package aes_uart_pkg;

  localparam logic [7:0] AsciiCr = 8'h0D;
  localparam logic [7:0] AsciiLf = 8'h0A;
  localparam logic [7:0] AsciiKu = 8'h4B;
  localparam logic [7:0] AsciiKl = 8'h6B;
  localparam logic [7:0] AsciiPu = 8'h50;
  localparam logic [7:0] AsciiPl = 8'h70;
  localparam logic [7:0] AsciiEu = 8'h45;
  localparam logic [7:0] AsciiEl = 8'h65;
  localparam logic [7:0] AsciiDu = 8'h44;
  localparam logic [7:0] AsciiDl = 8'h64;

  localparam int unsigned HexDigits = 32;

  typedef enum logic [1:0] {
    StIdle,
    StHex,
    StCmdEol,
    StResync
  } parser_state_e;

  // Returns {valid, nibble}; nibble is zero when the byte is not a hex digit.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, 4'(c - 8'h30)};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r = {1'b1, 4'(c - 8'h37)};
    end else if (c >= 8'h61 && c <= 8'h66) begin
      r = {1'b1, 4'(c - 8'h57)};
    end
    return r;
  endfunction

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchronizer, start-bit glitch rejection, mid-bit sampling.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
      state_q    <= RxIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RxIdle: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          bit_d = '0;
          // Line back high at the midpoint means a glitch, not a start bit.
          state_d = rxd_sync_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {rxd_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RxStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          state_d = RxIdle;
          valid_d = rxd_sync_q;
          ferr_d  = !rxd_sync_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign rx_valid = valid_q;
  assign rx_byte  = shift_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/aes_uart_loader.sv
// Parses ASCII K/P/E/D frames from the UART and drives the AES core load/start interface.
module aes_uart_loader
  import aes_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         uart_rxd,
  input  logic         core_ready,
  output logic [127:0] key_out,
  output logic [127:0] data_out,
  output logic         enc_dec,
  output logic         start,
  output logic         cmd_err
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_byte;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rxd(uart_rxd),
    .rx_valid(rx_valid),
    .rx_byte (rx_byte),
    .rx_ferr (rx_ferr)
  );

  parser_state_e state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [127:0]  shift_q, shift_d;
  logic [127:0]  key_q, key_d;
  logic [127:0]  data_q, data_d;
  logic          tgt_key_q, tgt_key_d;
  logic          mode_q, mode_d;
  logic          enc_dec_q, enc_dec_d;
  logic          start_q, start_d;
  logic          err_q, err_d;

  logic [4:0] dig;
  logic       is_term, is_k, is_p, is_e, is_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      key_q     <= '0;
      data_q    <= '0;
      tgt_key_q <= 1'b0;
      mode_q    <= 1'b1;
      enc_dec_q <= 1'b1;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      key_q     <= key_d;
      data_q    <= data_d;
      tgt_key_q <= tgt_key_d;
      mode_q    <= mode_d;
      enc_dec_q <= enc_dec_d;
      start_q   <= start_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    key_d     = key_q;
    data_d    = data_q;
    tgt_key_d = tgt_key_q;
    mode_d    = mode_q;
    enc_dec_d = enc_dec_q;
    start_d   = 1'b0;
    err_d     = 1'b0;

    dig     = hex_decode(rx_byte);
    is_term = (rx_byte == AsciiCr) || (rx_byte == AsciiLf);
    is_k    = (rx_byte == AsciiKu) || (rx_byte == AsciiKl);
    is_p    = (rx_byte == AsciiPu) || (rx_byte == AsciiPl);
    is_e    = (rx_byte == AsciiEu) || (rx_byte == AsciiEl);
    is_d    = (rx_byte == AsciiDu) || (rx_byte == AsciiDl);

    if (rx_ferr) begin
      // Resync already suppresses errors until the next terminator.
      err_d   = (state_q != StResync);
      state_d = StResync;
    end else if (rx_valid) begin
      case (state_q)
        StIdle: begin
          if (is_k || is_p) begin
            tgt_key_d = is_k;
            cnt_d     = '0;
            state_d   = StHex;
          end else if (is_e || is_d) begin
            mode_d  = is_e;
            state_d = StCmdEol;
          end else if (!is_term) begin
            err_d   = 1'b1;
            state_d = StResync;
          end
        end
        StHex: begin
          if (dig[4] && (cnt_q < 6'(HexDigits))) begin
            shift_d = {shift_q[123:0], dig[3:0]};
            cnt_d   = cnt_q + 6'd1;
          end else if (is_term) begin
            state_d = StIdle;
            if ((cnt_q == 6'(HexDigits)) && core_ready) begin
              if (tgt_key_q) key_d = shift_q;
              else           data_d = shift_q;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = StResync;
          end
        end
        StCmdEol: begin
          if (is_term) begin
            state_d = StIdle;
            if (core_ready) begin
              enc_dec_d = mode_q;
              start_d   = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = StResync;
          end
        end
        StResync: begin
          if (is_term) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign key_out  = key_q;
  assign data_out = data_q;
  assign enc_dec  = enc_dec_q;
  assign start    = start_q;
  assign cmd_err  = err_q;

endmodule
